// File: rtl/axi4_stream_packet_generator.sv
// AXI4-Stream test-packet source: counting-byte payload, per-packet TID, optional run length.
// Define AXIS_GEN_INTER_PACKET_GAP_EN to insert GAP_CYCLES idle cycles between packets.
module axi4_stream_packet_generator #(
  parameter int DATA_BYTES = 4,
  parameter int TID_WIDTH  = 8,
  parameter int DEST_VALUE = 0,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      ACLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [31:0]               PKT_BYTES,
  input  logic [15:0]               PKT_COUNT,
  input  logic                      TREADY,
  output logic                      TVALID,
  output logic [8*DATA_BYTES-1:0]   TDATA,
  output logic [DATA_BYTES-1:0]     TKEEP,
  output logic [DATA_BYTES-1:0]     TSTRB,
  output logic                      TLAST,
  output logic [TID_WIDTH-1:0]      TID,
  output logic [1:0]                TDEST,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [31:0]               PKTS_SENT
);

`ifdef AXIS_GEN_INTER_PACKET_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam int SH = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_t;

  state_t                  state;
  logic [31:0]             beats_rem;
  logic [7:0]              base;
  logic [DATA_BYTES-1:0]   last_keep;
  logic [15:0]             run_lim;
  logic [15:0]             run_sent;
  logic [7:0]              gap_cnt;

  logic [31:0]             eff_len;
  logic [31:0]             first_rem;
  logic [DATA_BYTES-1:0]   first_last_keep;
  logic [DATA_BYTES-1:0]   first_keep;
  logic [31:0]             next_rem;
  logic [7:0]              next_base;
  logic [DATA_BYTES-1:0]   next_keep;
  logic                    reached;
  logic                    load_pkt;

  function automatic logic [DATA_BYTES-1:0] tail_keep(input logic [31:0] len);
    logic [31:0]           rem;
    logic [DATA_BYTES-1:0] k;
    rem = len & 32'(DATA_BYTES - 1);
    for (int i = 0; i < DATA_BYTES; i++) k[i] = (32'(i) < rem);
    return (rem == 32'd0) ? '1 : k;
  endfunction

  // Lanes outside the keep mask are forced to zero.
  function automatic logic [8*DATA_BYTES-1:0] beat_data(input logic [7:0] b,
                                                        input logic [DATA_BYTES-1:0] keep);
    logic [8*DATA_BYTES-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      if (keep[i]) d[8*i +: 8] = b + 8'(i);
    return d;
  endfunction

  // Beat count minus one is (L-1)/DATA_BYTES, which cannot overflow for L up to 2^32-1.
  always_comb begin
    eff_len         = (PKT_BYTES == 32'd0) ? 32'd1 : PKT_BYTES;
    first_rem       = (eff_len - 32'd1) >> SH;
    first_last_keep = tail_keep(eff_len);
    first_keep      = (first_rem == 32'd0) ? first_last_keep : '1;
    next_rem        = beats_rem - 32'd1;
    next_base       = base + 8'(DATA_BYTES);
    next_keep       = (next_rem == 32'd0) ? last_keep : '1;
    reached         = (run_lim != 16'd0) && ((run_sent + 16'd1) == run_lim);
  end

  always_comb begin
    load_pkt = 1'b0;
    case (state)
      IDLE:    load_pkt = EN;
      SEND:    load_pkt = TVALID && TREADY && TLAST && !reached && EN && !GAP_EN;
      GAP:     load_pkt = (gap_cnt == 8'd0) && EN;
      default: load_pkt = 1'b0;
    endcase
  end

  assign TDEST = 2'(DEST_VALUE);

  always_ff @(posedge ACLK) begin
    if (RST) begin
      state     <= IDLE;
      TVALID    <= 1'b0;
      TLAST     <= 1'b0;
      TDATA     <= '0;
      TKEEP     <= '0;
      TSTRB     <= '0;
      TID       <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PKTS_SENT <= '0;
      beats_rem <= '0;
      base      <= '0;
      last_keep <= '0;
      run_lim   <= '0;
      run_sent  <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (EN) begin
            run_lim  <= PKT_COUNT;
            run_sent <= '0;
          end
        end
        SEND: begin
          if (TVALID && TREADY) begin
            if (TLAST) begin
              PKTS_SENT <= PKTS_SENT + 32'd1;
              TID       <= TID + TID_WIDTH'(1);
              run_sent  <= run_sent + 16'd1;
              TVALID    <= 1'b0;
              TLAST     <= 1'b0;
              TDATA     <= '0;
              TKEEP     <= '0;
              TSTRB     <= '0;
              if (reached) begin
                state <= HOLD;
                DONE  <= 1'b1;
              end else if (!EN) begin
                state <= IDLE;
                BUSY  <= 1'b0;
              end else if (GAP_EN) begin
                state   <= GAP;
                gap_cnt <= 8'(GAP_CYCLES - 1);
              end
            end else begin
              beats_rem <= next_rem;
              base      <= next_base;
              TKEEP     <= next_keep;
              TSTRB     <= next_keep;
              TLAST     <= (next_rem == 32'd0);
              TDATA     <= beat_data(next_base, next_keep);
            end
          end
        end
        GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (!EN) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        HOLD: begin
          if (!EN) begin
            state <= IDLE;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // First beat of a new packet; PKT_BYTES is captured here.
      if (load_pkt) begin
        state     <= SEND;
        BUSY      <= 1'b1;
        TVALID    <= 1'b1;
        TLAST     <= (first_rem == 32'd0);
        TKEEP     <= first_keep;
        TSTRB     <= first_keep;
        TDATA     <= beat_data(8'd0, first_keep);
        beats_rem <= first_rem;
        base      <= 8'd0;
        last_keep <= first_last_keep;
      end
    end
  end

endmodule

// File: tb/tb_axi4_stream_packet_generator.sv
// Randomised bench for axi4_stream_packet_generator with a transaction-level byte-stream model.
module tb_axi4_stream_packet_generator;
  localparam int DB   = 4;
  localparam int TW   = 2;
  localparam int DEST = 2;
  localparam int GAPC = 4;
`ifdef AXIS_GEN_INTER_PACKET_GAP_EN
  localparam int GAP_EXP = GAPC;
`else
  localparam int GAP_EXP = 0;
`endif

  logic          ACLK = 1'b0;
  logic          RST, EN, TREADY;
  logic [31:0]   PKT_BYTES;
  logic [15:0]   PKT_COUNT;
  logic          TVALID, TLAST, BUSY, DONE;
  logic [31:0]   TDATA, PKTS_SENT;
  logic [3:0]    TKEEP, TSTRB;
  logic [TW-1:0] TID;
  logic [1:0]    TDEST;

  axi4_stream_packet_generator #(
    .DATA_BYTES(DB), .TID_WIDTH(TW), .DEST_VALUE(DEST), .GAP_CYCLES(GAPC)
  ) dut (
    .ACLK(ACLK), .RST(RST), .EN(EN), .PKT_BYTES(PKT_BYTES), .PKT_COUNT(PKT_COUNT),
    .TREADY(TREADY), .TVALID(TVALID), .TDATA(TDATA), .TKEEP(TKEEP), .TSTRB(TSTRB),
    .TLAST(TLAST), .TID(TID), .TDEST(TDEST), .BUSY(BUSY), .DONE(DONE),
    .PKTS_SENT(PKTS_SENT)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: position in the current packet and run, and expected counters.
  int m_k, m_tid, m_sent, m_run_pkts, beats_seen, gap_len, rdy_mode;
  bit gap_arm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nbeats(input logic [31:0] pb);
    longint l;
    l = (pb == 0) ? 1 : longint'(pb);
    return int'((l + DB - 1) / DB);
  endfunction

  function automatic logic [3:0] exp_keep(input logic [31:0] pb, input int k);
    longint l, rem;
    l = (pb == 0) ? 1 : longint'(pb);
    if (k != nbeats(pb) - 1) return 4'hF;
    rem = l % DB;
    return (rem == 0) ? 4'hF : 4'((1 << rem) - 1);
  endfunction

  function automatic logic [31:0] exp_data(input logic [3:0] keep, input int k);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < DB; i++)
      if (keep[i]) d[8*i +: 8] = 8'((k * DB + i) % 256);
    return d;
  endfunction

  task automatic model_reset();
    m_k = 0; m_tid = 0; m_sent = 0; m_run_pkts = 0; beats_seen = 0;
    gap_arm = 0; gap_len = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; TREADY = 1'b0;
    @(posedge ACLK); #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One clock: drive TREADY, capture pre-edge outputs, then score the cycle just ended.
  task automatic tick();
    logic        pv, pr, pl, pe;
    logic [31:0] pd;
    logic [3:0]  pk, ps, ek;
    logic [1:0]  pt;
    case (rdy_mode)
      0:       TREADY = 1'b1;
      1:       TREADY = ~TREADY;
      default: TREADY = ($urandom % 4) != 0;
    endcase
    pv = TVALID; pr = TREADY; pd = TDATA; pk = TKEEP; ps = TSTRB; pl = TLAST; pt = TID; pe = EN;
    @(posedge ACLK); #1;
    if (pv && pr) begin
      ek = exp_keep(PKT_BYTES, m_k);
      check("tdata", 64'(pd), 64'(exp_data(ek, m_k)));
      check("tkeep", 64'(pk), 64'(ek));
      check("tstrb", 64'(ps), 64'(ek));
      check("tlast", 64'(pl), 64'(m_k == nbeats(PKT_BYTES) - 1));
      check("tid", 64'(pt), 64'(m_tid));
      if (gap_arm) begin
        check("gap_len", 64'(gap_len), 64'(GAP_EXP));
        gap_arm = 0;
      end
      beats_seen++;
      if (pl) begin
        m_k = 0;
        m_tid = (m_tid + 1) % (1 << TW);
        m_sent++;
        m_run_pkts++;
        check("pkts_sent", 64'(PKTS_SENT), 64'(m_sent));
        if (pe && !(PKT_COUNT != 0 && m_run_pkts == int'(PKT_COUNT))) begin
          gap_arm = 1; gap_len = 0;
        end
      end else begin
        m_k++;
      end
    end else if (pv) begin
      check("stall_hold", 64'({TVALID, TDATA, TKEEP, TSTRB, TLAST, TID}),
            64'({1'b1, pd, pk, ps, pl, pt}));
    end else if (gap_arm) begin
      gap_len++;
    end
    if (DONE) check("hold_tvalid", 64'(TVALID), 64'(0));
  endtask

  task automatic run(input logic [31:0] pb, input logic [15:0] cnt, input int mode);
    int bound;
    PKT_BYTES = pb; PKT_COUNT = cnt; rdy_mode = mode;
    m_run_pkts = 0; m_k = 0; gap_arm = 0; beats_seen = 0;
    EN = 1'b1;
    tick();
    check("tvalid_latency", 64'(TVALID), 64'(1));
    check("busy_run", 64'(BUSY), 64'(1));
    bound = 0;
    while (!DONE && bound < 5000) begin tick(); bound++; end
    check("done_reached", 64'(DONE), 64'(1));
    check("run_pkts", 64'(m_run_pkts), 64'(cnt));
    check("beats", 64'(beats_seen), 64'(int'(cnt) * nbeats(pb)));
    EN = 1'b0;
    tick();
    check("done_clear", 64'(DONE), 64'(0));
    check("busy_idle", 64'(BUSY), 64'(0));
  endtask

  initial begin
    int bound;
    RST = 1'b1; EN = 1'b0; TREADY = 1'b0; PKT_BYTES = '0; PKT_COUNT = '0; rdy_mode = 0;
    do_reset();
    check("rst_tvalid", 64'(TVALID), 64'(0));
    check("rst_tdata", 64'(TDATA), 64'(0));
    check("rst_tkeep", 64'({TKEEP, TSTRB}), 64'(0));
    check("rst_flags", 64'({TLAST, BUSY, DONE}), 64'(0));
    check("rst_tid", 64'(TID), 64'(0));
    check("rst_pkts", 64'(PKTS_SENT), 64'(0));
    check("tdest", 64'(TDEST), 64'(DEST));

    // 10-byte packet: keep F,F,3
    run(32'd10, 16'd1, 0);
    check("pkts_after_first", 64'(PKTS_SENT), 64'(1));
    // 8 bytes with ready toggling every cycle
    run(32'd8, 16'd1, 1);
    // zero length is a single 1-byte beat
    run(32'd0, 16'd1, 0);
    // back-to-back multi-packet run
    run(32'd7, 16'd3, 0);

    for (int r = 0; r < 8; r++) begin
      logic [31:0] pb;
      pb = (($urandom % 6) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      run(pb, 16'($urandom_range(1, 3)), 2);
    end

    // TID wraps at 2 bits over five packets
    do_reset();
    run(32'd4, 16'd5, 2);
    check("tid_wrap", 64'(TID), 64'(1));

    // EN dropped during packet 2 of an unlimited run
    do_reset();
    PKT_BYTES = 32'd12; PKT_COUNT = 16'd0; rdy_mode = 0; m_run_pkts = 0;
    EN = 1'b1;
    bound = 0;
    while (!(m_run_pkts == 1 && m_k == 1) && bound < 200) begin tick(); bound++; end
    check("en_drop_reach", 64'(bound < 200), 64'(1));
    EN = 1'b0;
    bound = 0;
    while (BUSY && bound < 200) begin tick(); bound++; end
    check("en_drop_pkts", 64'(m_run_pkts), 64'(2));
    check("en_drop_tid", 64'(TID), 64'(2));
    check("en_drop_idle", 64'({BUSY, TVALID, DONE}), 64'(0));

    // Reset asserted while beat 2 is presented
    PKT_BYTES = 32'd16; PKT_COUNT = 16'd0; rdy_mode = 0; m_run_pkts = 0; m_k = 0;
    EN = 1'b1;
    tick();
    tick();
    check("pre_rst_beat2", 64'({TVALID, TDATA}), 64'({1'b1, 32'h07060504}));
    EN = 1'b0;
    RST = 1'b1;
    @(posedge ACLK); #1;
    RST = 1'b0;
    check("mid_rst_out", 64'({TVALID, TLAST, TKEEP, TSTRB, TID, BUSY, DONE}), 64'(0));
    check("mid_rst_data", 64'(TDATA), 64'(0));
    check("mid_rst_pkts", 64'(PKTS_SENT), 64'(0));
    model_reset();
    run(32'd5, 16'd2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
